// File: rtl/fpu_issue.sv
// Issue stage in front of the FPU: request FIFO, one-op-in-flight FSM, tagged response port.
// Define FPU_ISSUE_TIMEOUT_EN to bound the WAIT state to TIMEOUT cycles.
module fpu_issue #(
  parameter int DEPTH   = 2,
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [31:0]      req_x1,
  input  logic [31:0]      req_x2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_y,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_err,
  output logic [3:0]       fpu_ctl,
  output logic [31:0]      fpu_x1,
  output logic [31:0]      fpu_x2,
  output logic             fpu_en,
  input  logic             fpu_ready,
  input  logic [31:0]      fpu_y,
  output logic             busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  function automatic logic op_supported(input logic [3:0] op);
    case (op)
      4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd11, 4'd12, 4'd13, 4'd14: op_supported = 1'b1;
      default: op_supported = 1'b0;
    endcase
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) ptr_inc = {PTR_W{1'b0}};
    else                        ptr_inc = p + PTR_W'(1);
  endfunction

  logic [3:0]       op_mem_r  [DEPTH];
  logic [31:0]      x1_mem_r  [DEPTH];
  logic [31:0]      x2_mem_r  [DEPTH];
  logic [TAG_W-1:0] tag_mem_r [DEPTH];

  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] count_r, count_nxt_s;
  state_t           state_r, state_nxt_s;
  logic             push_s, pop_s, head_sup_s;
  logic             req_ready_r, res_valid_r, res_err_r, fpu_en_r, busy_r;
  logic [31:0]      res_y_r, fpu_x1_r, fpu_x2_r;
  logic [TAG_W-1:0] res_tag_r;
  logic [3:0]       fpu_ctl_r;
`ifdef FPU_ISSUE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_r;
  logic             tmo_hit_s;
  assign tmo_hit_s = (tmo_r == TMO_W'(TIMEOUT - 1));
`endif

  // The FSM only dequeues while idle, so only one op is ever in flight.
  assign push_s     = req_valid && req_ready_r;
  assign pop_s      = (state_r == S_IDLE) && (count_r != CNT_W'(0));
  assign head_sup_s = op_supported(op_mem_r[rd_ptr_r]);

  // FIFO storage, written on accepted requests only
  always_ff @(posedge clk) begin
    if (push_s) begin
      op_mem_r[wr_ptr_r]  <= req_op;
      x1_mem_r[wr_ptr_r]  <= req_x1;
      x2_mem_r[wr_ptr_r]  <= req_x2;
      tag_mem_r[wr_ptr_r] <= req_tag;
    end
  end

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_nxt_s = count_r;
    if (push_s && !pop_s)      count_nxt_s = count_r + CNT_W'(1);
    else if (!push_s && pop_s) count_nxt_s = count_r - CNT_W'(1);
    else                       count_nxt_s = count_r;
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (pop_s) state_nxt_s = head_sup_s ? S_ISSUE : S_RESP;
        else       state_nxt_s = S_IDLE;
      end
      S_ISSUE: state_nxt_s = S_WAIT;
      S_WAIT: begin
        if (fpu_ready) state_nxt_s = S_RESP;
`ifdef FPU_ISSUE_TIMEOUT_EN
        else if (tmo_hit_s) state_nxt_s = S_RESP;
`endif
        else state_nxt_s = S_WAIT;
      end
      S_RESP: begin
        if (res_ready) state_nxt_s = S_IDLE;
        else           state_nxt_s = S_RESP;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State, pointers and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      req_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      fpu_en_r    <= 1'b0;
      fpu_ctl_r   <= 4'd0;
      fpu_x1_r    <= 32'd0;
      fpu_x2_r    <= 32'd0;
      res_valid_r <= 1'b0;
      res_y_r     <= 32'd0;
      res_tag_r   <= {TAG_W{1'b0}};
      res_err_r   <= 1'b0;
`ifdef FPU_ISSUE_TIMEOUT_EN
      tmo_r       <= {TMO_W{1'b0}};
`endif
    end else begin
      state_r     <= state_nxt_s;
      count_r     <= count_nxt_s;
      req_ready_r <= (count_nxt_s != CNT_W'(DEPTH));
      busy_r      <= (state_nxt_s != S_IDLE) || (count_nxt_s != CNT_W'(0));
      fpu_en_r    <= (state_nxt_s == S_ISSUE);
      res_valid_r <= (state_nxt_s == S_RESP);
      if (push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      case (state_r)
        S_IDLE: begin
          if (pop_s) begin
            res_tag_r <= tag_mem_r[rd_ptr_r];
`ifdef FPU_ISSUE_TIMEOUT_EN
            tmo_r     <= {TMO_W{1'b0}};
`endif
            if (head_sup_s) begin
              fpu_ctl_r <= op_mem_r[rd_ptr_r];
              fpu_x1_r  <= x1_mem_r[rd_ptr_r];
              fpu_x2_r  <= x2_mem_r[rd_ptr_r];
            end else begin
              res_y_r   <= 32'd0;
              res_err_r <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (fpu_ready) begin
            res_y_r   <= fpu_y;
            res_err_r <= 1'b0;
            fpu_ctl_r <= 4'd0;
            fpu_x1_r  <= 32'd0;
            fpu_x2_r  <= 32'd0;
          end
`ifdef FPU_ISSUE_TIMEOUT_EN
          else if (tmo_hit_s) begin
            res_y_r   <= 32'd0;
            res_err_r <= 1'b1;
            fpu_ctl_r <= 4'd0;
            fpu_x1_r  <= 32'd0;
            fpu_x2_r  <= 32'd0;
          end else begin
            tmo_r <= tmo_r + TMO_W'(1);
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign req_ready = req_ready_r;
  assign res_valid = res_valid_r;
  assign res_y     = res_y_r;
  assign res_tag   = res_tag_r;
  assign res_err   = res_err_r;
  assign fpu_ctl   = fpu_ctl_r;
  assign fpu_x1    = fpu_x1_r;
  assign fpu_x2    = fpu_x2_r;
  assign fpu_en    = fpu_en_r;
  assign busy      = busy_r;

endmodule

// File: doc/fpu_issue.md
# fpu_issue

Issue stage directly upstream of the FPU wrapper. It accepts floating-point requests from the core through a valid/ready queue and drives the FPU's `ctl`/`x1`/`x2`/`en` interface with a one-cycle `en` pulse, holding operands stable until the FPU returns `ready`. It then returns the result with its destination tag on a valid/ready response port. Opcodes the FPU does not implement are rejected locally, so the core never waits on a `ready` that will not arrive.

## Interface
- `DEPTH`, 2: request FIFO entries, ≥1.
- `TAG_W`, 5: destination-register tag width.
- `TIMEOUT`, 31: maximum cycles spent in WAIT (only with macro).

Clock and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: `!fifo_full`. Registered, no same-cycle bypass.
- `req_op` in 4: FPU ctl code.
- `req_x1`, `req_x2` in 32: operands.
- `req_tag` in TAG_W: destination tag.
- `res_valid` out 1: response present.
- `res_ready` in 1: consumer accepts.
- `res_y` out 32: result. Compares return {31'b0, bit}.
- `res_tag` out TAG_W: tag of the response.
- `res_err` out 1: unsupported op or timeout.
- `fpu_ctl` out 4; `fpu_x1`, `fpu_x2` out 32: to FPU.
- `fpu_en` out 1: one-cycle start pulse.
- `fpu_ready` in 1; `fpu_y` in 32: from FPU.
- `busy` out 1: FSM not IDLE or FIFO non-empty.

## Operation
- Supported ops: 2 fadd, 3 fsub, 4 fmul, 5 finv, 6 fdiv, 7 fhalf, 11 feq, 12 fle, 13 fabs, 14 fneg. All other codes are unsupported.
- FIFO: push on `req_valid && req_ready`; pop only in IDLE. Full ⇒ `req_ready=0`. Push and pop in the same cycle are both allowed when not full. Pointers wrap modulo DEPTH. Occupancy counter is `$clog2(DEPTH+1)` bits.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - **IDLE**: if the FIFO is non-empty, pop the head into op/x1/x2/tag registers and clear the timeout counter. Supported op → ISSUE. Unsupported op → RESP with `res_err=1`, `res_y=0`, and no FPU activity.
  - **ISSUE**: `fpu_en=1` for exactly this cycle → WAIT.
  - **WAIT**: `fpu_en=0`. On `fpu_ready=1`, capture `fpu_y` into `res_y`, set `res_err=0` → RESP. `fpu_ready` is ignored in every other state.
  - **RESP**: `res_valid=1`, all response outputs held stable. On `res_ready` → IDLE.
- `fpu_ctl`/`fpu_x1`/`fpu_x2` equal the op registers in ISSUE and WAIT, and are 0 in IDLE/RESP (ctl 0 is a no-op for the FPU).
- Exactly one op is in flight; the next pop occurs in the IDLE cycle after the response handshake.
- The FPU's active-low reset is driven from `~rst`, so reset clears both sides and no stale `fpu_ready` can reach a later WAIT.

## Timing
- Reset: `req_ready=1` (DEPTH≥1), `res_valid=0`, `res_y=0`, `res_tag=0`, `res_err=0`, `fpu_en=0`, `fpu_ctl=0`, `fpu_x1=0`, `fpu_x2=0`, `busy=0`, FIFO empty, state IDLE.
- Reset mid-operation flushes the FIFO and drops any pending response; reset has priority over all handshakes.
- FPU stage counts N: fadd 2, fsub 2, fmul 3, finv 4, fdiv 9, all others 1. `fpu_ready` is seen N cycles after the `fpu_en` cycle.
- Request accepted in cycle T (empty FIFO, FSM IDLE):
  - pop at T+1;
  - `fpu_en` at T+2;
  - `res_valid` from T+3+N.
  - Unsupported op: `res_valid` at T+2.
- Back-to-back throughput is N+3 cycles per op when `res_ready` is held high.

## Configuration
- `FPU_ISSUE_TIMEOUT_EN` defined: a counter runs in WAIT. If it reaches TIMEOUT without `fpu_ready`, go to RESP with `res_err=1`, `res_y=0`. A `fpu_ready` arriving in the same cycle as the limit wins, returning the result with `res_err=0`.
- Undefined: no counter; WAIT lasts until `fpu_ready`, and `res_err` is set only for unsupported ops.

## Test plan
- fadd: x1=0x3F800000, x2=0x40000000, tag 3 → `fpu_en` for one cycle at T+2, `res_valid` at T+5 with `res_y=0x40400000`, `res_tag=3`, `res_err=0`.
- fmul then fdiv back-to-back: 2.0×3.0 → 0x40C00000; 6.0/2.0 → 0x40400000. Responses arrive in order; `fpu_ctl`/`fpu_x1`/`fpu_x2` stay stable throughout each WAIT.
- fle: 1.0 ≤ 2.0 → `res_y=0x00000001`; feq: 1.0 vs 2.0 → `res_y=0x00000000`.
- op 8, tag 7 → `res_err=1`, `res_y=0`, `res_tag=7` at T+2; `fpu_en` never asserted.
- Hold `res_ready=0` and push DEPTH+2 requests → `req_ready` drops at full; no request is lost or reordered after release. Assert `rst` mid-WAIT → all outputs return to reset values next cycle.
- Macro defined, FPU stub never readies → `res_err=1` after TIMEOUT WAIT cycles. Macro undefined, same stub → remains in WAIT and `busy=1`.
